unary_bsg_array: RTL and testbench

- Lane array of unary bitstream generators that sits directly downstream of the shared counter array.
- Accepts one binary word per lane through a valid/ready handshake.
- Compares each word against that lane's shared count and emits one unary bit per lane per cycle for a window of 2^CWID cycles.
- Drives the enable of the upstream counter so the counter advances exactly one full period per window.

---
 rtl/unary_bsg_array.sv | 140 ++++++++++++++
 tb/tb_unary_bsg_array.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_bsg_array.sv
// Lane array of unary bitstream generators fed by a shared upstream counter.
// Each accepted word set is compared against that lane's count for 2^CWID
// cycles, so the number of ones per lane per window equals the lane's word.
// Ports:
//   clk, rst_n      clock; synchronous active-high reset (asserted = 1)
//   in_valid/ready  word set handshake; in_data packs lane k at [k*CWID +: CWID]
//   cnt_seq         upstream counts, same packing; cnt_en drives their enable
//   bit_out         one unary bit per lane, qualified by bit_valid
//   done            pulse with the last bit_valid of a window
//   busy            high whenever a window is being primed or run
module unary_bsg_array #(
  parameter int unsigned CWID  = 10,
  parameter int unsigned LANES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*CWID-1:0] in_data,
  input  logic [LANES*CWID-1:0] cnt_seq,
  output logic                  cnt_en,
  output logic [LANES-1:0]      bit_out,
  output logic                  bit_valid,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned WIN = 2**CWID;
  localparam int unsigned RW  = CWID + 1;
  localparam int unsigned DW  = LANES * CWID;
  localparam logic [RW-1:0] LAST = RW'(WIN - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   active_q, active_d;
  logic [DW-1:0]   pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [RW-1:0]   run_cnt_q, run_cnt_d;
  logic            cnt_en_d, in_ready_d, busy_d, bit_valid_d, done_d;
  logic [LANES-1:0] bit_out_d;
  logic [LANES-1:0] cmp_c;
  logic            hs_c;

  assign hs_c = in_valid && in_ready;

  // Per-lane unsigned compare of the running word against its count
  always_comb begin
    cmp_c = '0;
    for (int k = 0; k < LANES; k++) begin
      cmp_c[k] = active_q[k*CWID +: CWID] > cnt_seq[k*CWID +: CWID];
    end
  end

  // Next-state and next-output logic; outputs are registered from next state
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    run_cnt_d   = run_cnt_q;

    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          active_d    = pend_q;
          pend_full_d = 1'b0;
          state_d     = PRIME;
        end else if (hs_c) begin
          active_d = in_data;
          state_d  = PRIME;
        end
      end
      PRIME: begin
        run_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (run_cnt_q == LAST) begin
          if (pend_full_q) begin
            // Last cycle doubles as PRIME for the queued word: gapless stream
            active_d    = pend_q;
            pend_full_d = 1'b0;
            run_cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          run_cnt_d = run_cnt_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outside IDLE fills the shadow; only possible while it is empty
    if (hs_c && (state_q != IDLE)) begin
      pend_d      = in_data;
      pend_full_d = 1'b1;
    end

    // Enable for the upcoming cycle: WIN enables per window keeps phase mod WIN
    cnt_en_d    = (state_d == PRIME) ||
                  ((state_d == RUN) && ((run_cnt_d != LAST) || pend_full_d));
    in_ready_d  = !pend_full_d;
    busy_d      = (state_d != IDLE);
    bit_valid_d = (state_q == RUN);
    bit_out_d   = (state_q == RUN) ? cmp_c : '0;
    done_d      = (state_q == RUN) && (run_cnt_q == LAST);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      run_cnt_q   <= '0;
      cnt_en      <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      bit_valid   <= 1'b0;
      bit_out     <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      run_cnt_q   <= run_cnt_d;
      cnt_en      <= cnt_en_d;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
      bit_valid   <= bit_valid_d;
      bit_out     <= bit_out_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_unary_bsg_array.sv
// Self-checking bench for unary_bsg_array: upstream counter environment,
// table-driven single windows, hand-written multi-window sequences and a
// randomized run scored against per-window ones counts.
module tb_unary_bsg_array;

  localparam int unsigned CWID  = 10;
  localparam int unsigned LANES = 16;
  localparam int unsigned WIN   = 2**CWID;
  localparam int unsigned DW    = LANES * CWID;
  localparam int unsigned AW    = CWID + 1;

  typedef logic [LANES*AW-1:0] win_t;

  typedef struct {
    int unsigned base;
    int unsigned step;
    int unsigned phase;
    int unsigned exp0;
    int unsigned exp15;
    bit          chk_zero;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] cnt_seq;
  logic cnt_en;
  logic [LANES-1:0] bit_out;
  logic bit_valid;
  logic done;
  logic busy;

  logic [CWID-1:0] cnt_val = '0;
  logic [CWID-1:0] cnt_seq_r = '0;
  logic adv_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int en_tot = 0;
  int val_tot = 0;
  int done_tot = 0;
  int orphan = 0;
  int cur_run = 0;
  int run_at_done = 0;
  int last_done = 0;
  int done_gap = 0;
  int zero0_tot = 0;
  int zero0_seq = -1;
  int prev_seq = 0;
  int win_acc [LANES];

  win_t got_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign cnt_seq = {LANES{cnt_seq_r}};

  unary_bsg_array #(.CWID(CWID), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cnt_seq(cnt_seq), .cnt_en(cnt_en), .bit_out(bit_out),
    .bit_valid(bit_valid), .done(done), .busy(busy)
  );

  // Upstream counter with one register stage on its output
  always @(posedge clk) begin
    if (cnt_en || adv_en) cnt_val <= cnt_val + 1'b1;
    cnt_seq_r <= cnt_val;
  end

  // Output monitor: accumulates ones per lane per window and stream statistics
  always @(negedge clk) begin
    win_t v;
    cyc++;
    if (rst_n) begin
      for (int k = 0; k < LANES; k++) win_acc[k] = 0;
      cur_run = 0;
    end else begin
      if (cnt_en) en_tot++;
      if (bit_valid) begin
        val_tot++;
        cur_run++;
        for (int k = 0; k < LANES; k++) win_acc[k] += int'(bit_out[k]);
        if (!bit_out[0]) begin
          zero0_tot++;
          zero0_seq = prev_seq;
        end
      end else begin
        cur_run = 0;
      end
      if (done) begin
        if (!bit_valid) orphan++;
        done_tot++;
        done_gap = cyc - last_done;
        last_done = cyc;
        run_at_done = cur_run;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
          v[k*AW +: AW] = AW'(win_acc[k]);
          win_acc[k] = 0;
        end
        got_q.push_back(v);
      end
    end
    prev_seq = int'(cnt_seq_r);
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input bit hold);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      tick();
      n++;
    end
    chk("send_accept", int'(in_ready), 1);
    if (in_ready) begin
      tick();
      exp_q.push_back(w);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int n = 0;
    while (done_tot < target && n < limit) begin
      tick();
      n++;
    end
    chk(name, int'(done_tot >= target), 1);
  endtask

  task automatic drain(input string name);
    win_t g;
    logic [DW-1:0] w;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      w = exp_q.pop_front();
      for (int k = 0; k < LANES; k++)
        chk($sformatf("%s_ones_lane%0d", name, k), int'(g[k*AW +: AW]), int'(w[k*CWID +: CWID]));
    end
    chk($sformatf("%s_leftover", name), got_q.size() + exp_q.size(), 0);
  endtask

  function automatic logic [DW-1:0] make_word(input int unsigned base, input int unsigned step);
    logic [DW-1:0] w;
    for (int k = 0; k < LANES; k++) w[k*CWID +: CWID] = CWID'(base + step * k);
    return w;
  endfunction

  initial begin
    row_t rows [4];
    int en0, val0, d0, z0, ph, n;
    logic [DW-1:0] wa, wb, wc;

    rows[0] = '{base: 0,    step: 0,  phase: 0,   exp0: 0,    exp15: 0,    chk_zero: 1'b0};
    rows[1] = '{base: 0,    step: 64, phase: 357, exp0: 0,    exp15: 960,  chk_zero: 1'b0};
    rows[2] = '{base: 1023, step: 0,  phase: 357, exp0: 1023, exp15: 1023, chk_zero: 1'b1};
    rows[3] = '{base: 5,    step: 37, phase: 100, exp0: 5,    exp15: 560,  chk_zero: 1'b0};

    // Reset values
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bit_out", int'(bit_out), 0);
    rst_n = 1'b0;
    tick();
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_busy", int'(busy), 0);

    // Table-driven single windows
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (cnt_val != CWID'(rows[r].phase) && n < 1100) begin
        adv_en = 1'b1;
        tick();
        n++;
      end
      adv_en = 1'b0;
      tick();
      en0 = en_tot; val0 = val_tot; d0 = done_tot; z0 = zero0_tot;
      send(make_word(rows[r].base, rows[r].step), 1'b0);
      wait_done(d0 + 1, 1200, $sformatf("row%0d_done_seen", r));
      repeat (3) tick();
      chk($sformatf("row%0d_done_cnt", r), done_tot - d0, 1);
      chk($sformatf("row%0d_cnt_en", r), en_tot - en0, WIN);
      chk($sformatf("row%0d_valid", r), val_tot - val0, WIN);
      chk($sformatf("row%0d_run", r), run_at_done, WIN);
      chk($sformatf("row%0d_phase", r), int'(cnt_val), int'(rows[r].phase));
      chk($sformatf("row%0d_busy", r), int'(busy), 0);
      if (got_q.size() > 0) begin
        chk($sformatf("row%0d_lane0", r), int'(got_q[0][0 +: AW]), int'(rows[r].exp0));
        chk($sformatf("row%0d_lane15", r), int'(got_q[0][15*AW +: AW]), int'(rows[r].exp15));
      end
      if (rows[r].chk_zero) begin
        chk($sformatf("row%0d_zeros", r), zero0_tot - z0, 1);
        chk($sformatf("row%0d_zero_seq", r), zero0_seq, 1023);
      end
      drain($sformatf("row%0d", r));
    end

    // Back-to-back: second set offered 10 cycles into RUN
    wa = make_word(100, 50);
    wb = make_word(1000, 3);
    en0 = en_tot; d0 = done_tot; ph = int'(cnt_val);
    send(wa, 1'b0);
    repeat (11) tick();
    send(wb, 1'b0);
    chk("b2b_ready_drop", int'(in_ready), 0);
    wait_done(d0 + 1, 1200, "b2b_done1_seen");
    wait_done(d0 + 2, 1200, "b2b_done2_seen");
    chk("b2b_gap", done_gap, WIN);
    chk("b2b_run", run_at_done, 2 * WIN);
    repeat (3) tick();
    chk("b2b_cnt_en", en_tot - en0, 2 * WIN);
    chk("b2b_phase", int'(cnt_val), ph);
    drain("b2b");

    // Reset mid-window with a pending word held
    d0 = done_tot;
    send(make_word(7, 9), 1'b0);
    repeat (5) tick();
    send(make_word(300, 1), 1'b0);
    repeat (494) tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_bit_out", int'(bit_out), 0);
    chk("mid_rst_bit_valid", int'(bit_valid), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_cnt_en", int'(cnt_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ready_after", int'(in_ready), 1);
    repeat (4) tick();
    chk("mid_rst_pend_dropped", int'(busy), 0);
    chk("mid_rst_no_done", done_tot - d0, 0);
    exp_q.delete();
    got_q.delete();
    en0 = en_tot; d0 = done_tot;
    send(make_word(512, 31), 1'b0);
    wait_done(d0 + 1, 1200, "post_rst_done_seen");
    repeat (3) tick();
    chk("post_rst_cnt_en", en_tot - en0, WIN);
    drain("post_rst");

    // in_valid held high across three word sets
    wa = make_word(11, 60);
    wb = make_word(900, 7);
    wc = make_word(1, 1);
    d0 = done_tot; en0 = en_tot;
    send(wa, 1'b1);
    send(wb, 1'b1);
    in_data = wc;
    repeat (100) tick();
    chk("hold_ready_low", int'(in_ready), 0);
    send(wc, 1'b0);
    wait_done(d0 + 3, 3500, "hold_done_seen");
    repeat (3) tick();
    chk("hold_done_cnt", done_tot - d0, 3);
    chk("hold_cnt_en", en_tot - en0, 3 * WIN);
    drain("hold");

    // Randomized word sets with random gaps
    d0 = done_tot; en0 = en_tot; ph = int'(cnt_val);
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] w;
      repeat ($urandom_range(0, 40)) tick();
      for (int k = 0; k < LANES; k++) w[k*CWID +: CWID] = CWID'($urandom_range(0, WIN - 1));
      send(w, 1'b0);
    end
    wait_done(d0 + 6, 8000, "rand_done_seen");
    repeat (3) tick();
    chk("rand_cnt_en", en_tot - en0, 6 * WIN);
    chk("rand_phase", int'(cnt_val), ph);
    drain("rand");

    chk("done_orphan", orphan, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
